fb1_write_arbiter: RTL and testbench
====================================

Name: fb1_write_arbiter

Overview:
- Owns the write port (`arb_*`) of the 1-bit 1024x768 frame buffer.
- Shares that port between two requesters: CPU pixel writes and the graphics accelerator.
- Contains a fill sequencer that sweeps every pixel address to clear or set the screen.
- All frame-buffer-side outputs are registered; at most one write is issued per clock.

Parameters:
- NUM_PIXELS, 786432, number of addressable pixels (1024*768).
- ADDR_W, 20, pixel address width.

Ports:
- clk  in  1  system clock; also drives the frame buffer `arb_clk`.
- rst_n  in  1  asynchronous active-low reset.
- cpu_valid  in  1  CPU write request.
- cpu_ready  out  1  CPU request accepted this cycle (valid && ready).
- cpu_addr  in  ADDR_W  CPU pixel address.
- cpu_din  in  1  CPU pixel value.
- acc_valid  in  1  accelerator write request.
- acc_ready  out  1  accelerator request accepted this cycle.
- acc_addr  in  ADDR_W  accelerator pixel address.
- acc_din  in  1  accelerator pixel value.
- fill_start  in  1  single-cycle pulse that starts a full-screen fill.
- fill_value  in  1  pixel value written by the fill; sampled with fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  single-cycle pulse after the last fill write is issued.
- arb_we  out  1  frame buffer write enable.
- arb_addr  out  ADDR_W  frame buffer address.
- arb_din  out  1  frame buffer write data.

Behaviour:
- Single clock domain (clk); rst_n is asynchronous, active-low.
- Reset values: arb_we=0, arb_addr=0, arb_din=0, fill_busy=0, fill_done=0, fill counter=0, state=IDLE, round-robin pointer=CPU.
- States:
  - IDLE: arbitrates requesters.
  - FILL: sweeps addresses.
- IDLE behaviour:
  - At most one of cpu_ready/acc_ready is high.
  - A ready is high only when its own valid is high and it holds the grant.
  - Ready is combinational from the valids and the pointer.
  - The accepted request appears on arb_we/arb_addr/arb_din on the next cycle, i.e. 1-cycle latency.
  - Throughput is one write per cycle.
  - With no acceptance, arb_we=0 next cycle; arb_addr/arb_din hold their previous values.
- Out-of-range address (addr >= NUM_PIXELS):
  - The request is still accepted (ready=1) so the requester never hangs.
  - No write is issued: arb_we=0 next cycle.
- fill_start sampled in IDLE:
  - Latches fill_value and enters FILL the next cycle.
  - A requester may still be granted in that same cycle.
- fill_start while fill_busy=1 is ignored.
- FILL behaviour:
  - cpu_ready=acc_ready=0.
  - Counter runs 0..NUM_PIXELS-1, one registered write per cycle: arb_we=1, arb_addr=counter, arb_din=latched value.
  - fill_busy=1 for the entire FILL state.
  - After the write of address NUM_PIXELS-1 is issued: return to IDLE, fill_busy=0, fill_done=1 for one cycle, counter cleared.
  - A fill occupies exactly NUM_PIXELS consecutive cycles of arb_we=1.
- rst_n asserted mid-fill aborts the fill immediately; outputs take their reset values and no fill_done is produced.
- Arithmetic: the counter is ADDR_W bits; the terminal compare is against NUM_PIXELS-1, so no wrap is needed.

Optional Feature:
- Macro: FB1_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin grant.
  - With both valid, the requester not granted last gets the grant.
  - The pointer updates only on acceptance of an in-range or out-of-range request.
- Undefined:
  - Fixed priority: CPU over accelerator.
  - No pointer register.

Decomposition:
- Shared package fb1_pkg holds:
  - FB1_NUM_PIXELS=786432.
  - FB1_ADDR_W=20.
  - State enum IDLE/FILL.
  - Requester index constants REQ_CPU=0, REQ_ACC=1.
- One natural sub-module, fb1_fill_seq: counter, busy/done generation and value latch.
- The arbitration and output register stay in the top.

Test Plan:
- Reset, then cpu_valid=1 addr=0x00010 din=1 -> cpu_ready=1 same cycle; next cycle arb_we=1, arb_addr=0x00010, arb_din=1.
- cpu_valid and acc_valid both high for 4 cycles, RR enabled -> grants alternate CPU,ACC,CPU,ACC. With macro undefined -> CPU granted all 4 cycles, acc_ready=0.
- acc_valid with addr=786432 -> acc_ready=1; next cycle arb_we=0.
- fill_start with fill_value=0 -> fill_busy=1 from next cycle; exactly 786432 writes, addresses 0..786431, arb_din=0; fill_done one pulse; requesters' ready=0 throughout.
- fill_start pulsed again at fill address 1000 -> ignored; the fill still ends at 786431 with a single fill_done.
- rst_n low at fill address 5000 -> arb_we=0, fill_busy=0 asynchronously; after release, IDLE with no fill_done.

Source files
------------

// File: rtl/fb1_pkg.sv
// fb1 frame-buffer write path: shared constants and types.
// Used by fb1_write_arbiter and fb1_fill_seq.
package fb1_pkg;
  localparam int FB1_NUM_PIXELS = 786432;
  localparam int FB1_ADDR_W = 20;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fb1_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_ACC = 1'b1;
endpackage

// File: rtl/fb1_fill_seq.sv
// fb1 fill sequencer: sweeps every pixel address once per fill.
// Latches the fill value and reports busy / done.
module fb1_fill_seq
  import fb1_pkg::*;
#(
  parameter int NUM_PIXELS = FB1_NUM_PIXELS,
  parameter int ADDR_W = FB1_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              value_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              value_o
);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_PIXELS - 1);

  fb1_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FILL;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            val_q   <= value_i;
          end
        end
        FILL: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign cnt_o   = cnt_q;
  assign value_o = val_q;
endmodule

// File: rtl/fb1_write_arbiter.sv
// fb1 frame-buffer write arbiter: CPU, accelerator and fill share arb_*.
// FB1_ARB_ROUND_ROBIN_EN selects round-robin instead of CPU priority.
module fb1_write_arbiter
  import fb1_pkg::*;
#(
  parameter int NUM_PIXELS = FB1_NUM_PIXELS,
  parameter int ADDR_W = FB1_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_din,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              acc_din,
  input  logic              fill_start,
  input  logic              fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              arb_we,
  output logic [ADDR_W-1:0] arb_addr,
  output logic              arb_din
);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_PIXELS - 1);

  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] fill_cnt;
  logic              fill_val;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              din_q, din_d;

  fb1_fill_seq #(
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_W    (ADDR_W)
  ) u_fill (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(fill_start),
    .value_i(fill_value),
    .busy_o (busy),
    .done_o (done),
    .cnt_o  (fill_cnt),
    .value_o(fill_val)
  );

`ifdef FB1_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  always_comb begin
    cpu_ready = 1'b0;
    acc_ready = 1'b0;
    if (!busy) begin
      if (cpu_valid && (!acc_valid || ptr_q == REQ_CPU))
        cpu_ready = 1'b1;
      else
        acc_ready = acc_valid;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (cpu_ready)
      ptr_d = REQ_ACC;
    else if (acc_ready)
      ptr_d = REQ_CPU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= REQ_CPU;
    else
      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    cpu_ready = !busy && cpu_valid;
    acc_ready = !busy && acc_valid && !cpu_valid;
  end
`endif

  // Out-of-range requests are accepted but leave addr/din untouched.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    unique case (1'b1)
      busy: begin
        we_d   = 1'b1;
        addr_d = fill_cnt;
        din_d  = fill_val;
      end
      cpu_ready: begin
        if (cpu_addr <= LAST) begin
          we_d   = 1'b1;
          addr_d = cpu_addr;
          din_d  = cpu_din;
        end
      end
      acc_ready: begin
        if (acc_addr <= LAST) begin
          we_d   = 1'b1;
          addr_d = acc_addr;
          din_d  = acc_din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign arb_we    = we_q;
  assign arb_addr  = addr_q;
  assign arb_din   = din_q;
  assign fill_busy = busy;
  assign fill_done = done;
endmodule

// File: tb/tb_fb1_write_arbiter.sv
// Scoreboard bench for fb1_write_arbiter with a reduced pixel count.
// Honors FB1_ARB_ROUND_ROBIN_EN in its reference model.
module tb_fb1_write_arbiter;
  localparam int NP = 2048;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_valid = 1'b0, cpu_din = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          acc_valid = 1'b0, acc_din = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic          fill_start = 1'b0, fill_value = 1'b0;
  logic          cpu_ready, acc_ready;
  logic          fill_busy, fill_done;
  logic          arb_we, arb_din;
  logic [AW-1:0] arb_addr;

  always #5 clk = ~clk;

  fb1_write_arbiter #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_addr(acc_addr), .acc_din(acc_din),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .arb_we(arb_we), .arb_addr(arb_addr), .arb_din(arb_din)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic          din;
    logic          busy;
    logic          done;
  } out_t;

  out_t       oq[$];
  logic [1:0] rq[$];
  int checks = 0;
  int failures = 0;

  bit            m_fill;
  int            m_idx;
  bit            m_val;
  logic [AW-1:0] m_addr;
  bit            m_din;
`ifdef FB1_ARB_ROUND_ROBIN_EN
  bit            m_ptr;
`endif

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fill = 0;
    m_idx  = 0;
    m_val  = 0;
    m_addr = '0;
    m_din  = 0;
`ifdef FB1_ARB_ROUND_ROBIN_EN
    m_ptr  = 0;
`endif
  endtask

  task automatic cyc(input bit rst, input bit cv,
                     input logic [AW-1:0] ca, input bit cd,
                     input bit av, input logic [AW-1:0] aa,
                     input bit ad, input bit fs, input bit fv);
    bit   gc, ga;
    out_t o;
    @(negedge clk);
    cpu_valid = cv; cpu_addr = ca; cpu_din = cd;
    acc_valid = av; acc_addr = aa; acc_din = ad;
    fill_start = fs; fill_value = fv;
    rst_n = rst;
    if (!rst) begin
      #1;
      chk("async_reset", {arb_we, fill_busy, fill_done}, 3'b000);
      model_reset();
      rq.push_back({cv, 1'b0} & 2'b00);
      oq.push_back('0);
      return;
    end
    gc = 0;
    ga = 0;
    if (!m_fill) begin
`ifdef FB1_ARB_ROUND_ROBIN_EN
      if (cv && av) begin
        gc = (m_ptr == 0);
        ga = !gc;
      end else begin
        gc = cv;
        ga = av;
      end
`else
      gc = cv;
      ga = av && !cv;
`endif
    end
    rq.push_back({gc, ga});
    o = '0;
    if (m_fill) begin
      o.we   = 1;
      m_addr = AW'(m_idx);
      m_din  = m_val;
      o.done = (m_idx == NP - 1);
      o.busy = !o.done;
      m_idx++;
      if (m_idx == NP) begin
        m_fill = 0;
        m_idx  = 0;
      end
    end else begin
      if (gc) begin
        if (int'(ca) < NP) begin
          o.we = 1; m_addr = ca; m_din = cd;
        end
`ifdef FB1_ARB_ROUND_ROBIN_EN
        m_ptr = 1;
`endif
      end else if (ga) begin
        if (int'(aa) < NP) begin
          o.we = 1; m_addr = aa; m_din = ad;
        end
`ifdef FB1_ARB_ROUND_ROBIN_EN
        m_ptr = 0;
`endif
      end
      o.busy = fs;
      if (fs) begin
        m_fill = 1;
        m_idx  = 0;
        m_val  = fv;
      end
    end
    o.addr = m_addr;
    o.din  = m_din;
    oq.push_back(o);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = $urandom_range(15);
    if (r == 0) return AW'(NP + $urandom_range(100));
    if (r == 1) return {AW{1'b1}};
    return AW'($urandom_range(NP - 1));
  endfunction

  task automatic rnd_cyc(input bit fs, input bit fv);
    cyc(1, 1'($urandom_range(1)), rnd_addr(), 1'($urandom_range(1)),
        1'($urandom_range(1)), rnd_addr(), 1'($urandom_range(1)),
        fs, fv);
  endtask

  task automatic do_fill(input bit fv, input int restart_at,
                         input int reset_at);
    rnd_cyc(1, fv);
    for (int k = 0; k < NP + 4 && m_fill; k++) begin
      if (reset_at >= 0 && m_idx == reset_at) begin
        cyc(0, 0, '0, 0, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, '0, 0, 0, 0);
        break;
      end
      rnd_cyc(m_idx == restart_at, 1'($urandom_range(1)));
    end
  endtask

  initial begin : mon_ready
    logic [1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("ready", {62'd0, cpu_ready, acc_ready}, {62'd0, e});
      end
    end
  end

  initial begin : mon_out
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (oq.size() > 0) begin
        e = oq.pop_front();
        chk("arb_out",
            {arb_we, arb_addr, arb_din, fill_busy, fill_done}, e);
      end
    end
  end

  initial begin : watchdog
    #1ms;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    repeat (3) cyc(0, 0, '0, 0, 0, '0, 0, 0, 0);
    cyc(1, 1, 20'h00010, 1, 0, '0, 0, 0, 0);
    cyc(1, 0, '0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(1, 1, AW'(16 * i + 32), 1, 1, AW'(16 * i + 40), 0, 0, 0);
    cyc(1, 0, '0, 0, 1, AW'(NP), 1, 0, 0);
    cyc(1, 0, '0, 0, 1, AW'(NP - 1), 1, 0, 0);
    cyc(1, 0, '0, 0, 0, '0, 0, 0, 0);
    repeat (300) rnd_cyc(0, 0);
    do_fill(0, 1000, -1);
    repeat (100) rnd_cyc(0, 0);
    do_fill(1, -1, -1);
    repeat (50) rnd_cyc(0, 0);
    do_fill(1, -1, 1500);
    repeat (100) rnd_cyc(0, 0);
    repeat (3) cyc(1, 0, '0, 0, 0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("queues_drained", 64'(rq.size() + oq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
